// File: rtl/stage_ex_muldiv_pkg.sv
// Shared encodings for the execute stage: ALU-op classes, M-extension
// funct codes, branch classes, next-pc selects and the stage FSM states.
package exec_pkg;

  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Branch classes presented on pc_op
  localparam logic [1:0] PCOP_NONE   = 2'b00;
  localparam logic [1:0] PCOP_BRANCH = 2'b01;
  localparam logic [1:0] PCOP_JAL    = 2'b10;
  localparam logic [1:0] PCOP_JALR   = 2'b11;

  // Next-pc selects driven on pcsrc
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} ex_state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_ctrl_t;

endpackage

// File: rtl/stage_ex_muldiv_if.sv
// Handshake and operand/result bundle between the ID step, the execute
// stage and the MEM/WB consumer.
interface stage_ex_muldiv_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic            a_sel;
  logic            b_sel;
  logic [1:0]      alu_op;
  logic [1:0]      pc_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_output;
  logic [XLEN-1:0] branch_output;
  logic [1:0]      pcsrc;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, a_sel, b_sel, alu_op, pc_op, funct3, funct7,
           pc, rdata1, rdata2, imm, out_ready,
    input  in_ready, out_valid, alu_output, branch_output, pcsrc, illegal, busy
  );

  modport slave (
    input  in_valid, a_sel, b_sel, alu_op, pc_op, funct3, funct7,
           pc, rdata1, rdata2, imm, out_ready,
    output in_ready, out_valid, alu_output, branch_output, pcsrc, illegal, busy
  );
endinterface

// File: rtl/stage_ex_muldiv_base.sv
// Base execute datapath blocks: operand mux, ALU decode, ALU, branch
// compare and the pc+imm target adder.

module Mux_2to1 #(parameter int W = 32) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module Adder #(parameter int W = 32) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// alu_op: 00 add (address calc), 01 sub (branch), 10 R-type, 11 I-type
module ALU_Control import exec_pkg::*; (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output alu_ctrl_t  alu_ctrl
);
  // Decode the ALU operation from the op class and funct fields
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000: alu_ctrl = (alu_op == ALUOP_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl = ALU_SLL;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end
endmodule

module ALU import exec_pkg::*; #(parameter int XLEN = 32) (
  input  alu_ctrl_t       alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SHW = $clog2(XLEN);
  logic [SHW-1:0] w_shamt;
  assign w_shamt = b[SHW-1:0];

  // Combinational ALU result
  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << w_shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> w_shamt;
      ALU_SRA:  y = $signed(a) >>> w_shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end
endmodule

// pcsrc: 0 sequential, 1 pc+imm (taken branch / JAL), 2 ALU target (JALR)
module Branch_Unit import exec_pkg::*; #(parameter int XLEN = 32) (
  input  logic [1:0]      pc_op,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [1:0]      pcsrc
);
  logic w_taken;

  // Branch condition from funct3 and next-pc select from the branch class
  always_comb begin
    case (funct3)
      3'b000:  w_taken = (rdata1 == rdata2);
      3'b001:  w_taken = (rdata1 != rdata2);
      3'b100:  w_taken = ($signed(rdata1) <  $signed(rdata2));
      3'b101:  w_taken = ($signed(rdata1) >= $signed(rdata2));
      3'b110:  w_taken = (rdata1 <  rdata2);
      3'b111:  w_taken = (rdata1 >= rdata2);
      default: w_taken = 1'b0;
    endcase
    case (pc_op)
      PCOP_BRANCH: pcsrc = w_taken ? PCSRC_TARGET : PCSRC_SEQ;
      PCOP_JAL:    pcsrc = PCSRC_TARGET;
      PCOP_JALR:   pcsrc = PCSRC_JALR;
      default:     pcsrc = PCSRC_SEQ;
    endcase
  end
endmodule

// File: rtl/stage_ex_muldiv_muldiv_iter.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with the sign fixed up during the last iteration.
// The divide special cases are detected combinationally from the raw
// operands so the stage can skip the iterative path for them.
module muldiv_iter import exec_pkg::*; #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic [XLEN-1:0] special_result,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [CW-1:0]     r_cnt;
  logic              r_active;
  logic [2:0]        r_op;
  logic [2*XLEN-1:0] r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_b;       // multiplicand or divisor magnitude
  logic              r_neg_lo;  // negate product / quotient
  logic              r_neg_hi;  // negate remainder

  logic              w_a_neg, w_b_neg, w_div_zero, w_ovf;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_addend, w_rem_new, w_lo_raw, w_hi_raw, w_q_fix, w_r_fix;
  logic [XLEN:0]     w_sum, w_rem_sh, w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_step, w_mul_fix;

  // Operand signs, magnitudes and divide special-case detection
  always_comb begin
    w_a_neg    = a[XLEN-1] && (op == F3_MULH || op == F3_MULHSU || op == F3_DIV || op == F3_REM);
    w_b_neg    = b[XLEN-1] && (op == F3_MULH || op == F3_DIV || op == F3_REM);
    w_a_mag    = w_a_neg ? -a : a;
    w_b_mag    = w_b_neg ? -b : b;
    w_div_zero = (b == '0);
    w_ovf      = !op[0] && (a == MIN_NEG) && (b == '1);
    special    = op[2] && (w_div_zero || w_ovf);
    if (w_div_zero) special_result = op[1] ? a : '1;
    else            special_result = op[1] ? '0 : a;
  end

  // One multiply or divide step plus the final sign fix-up
  always_comb begin
    w_addend   = r_acc[0] ? r_b : {XLEN{1'b0}};
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    w_mul_next = {w_sum, r_acc[XLEN-1:1]};
    w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_diff     = w_rem_sh - {1'b0, r_b};
    w_ge       = (w_rem_sh >= {1'b0, r_b});
    w_rem_new  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};
    w_step     = r_op[2] ? w_div_next : w_mul_next;
    w_mul_fix  = r_neg_lo ? -w_step : w_step;
    w_lo_raw   = w_step[XLEN-1:0];
    w_hi_raw   = w_step[2*XLEN-1:XLEN];
    w_q_fix    = r_neg_lo ? -w_lo_raw : w_lo_raw;
    w_r_fix    = r_neg_hi ? -w_hi_raw : w_hi_raw;
    if (r_op[2])              result = r_op[1] ? w_r_fix : w_q_fix;
    else if (r_op == F3_MUL)  result = w_mul_fix[XLEN-1:0];
    else                      result = w_mul_fix[2*XLEN-1:XLEN];
  end

  assign done = r_active && (r_cnt == LAST);

  // Operand capture on start, then one step per cycle until the count is spent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_op     <= op;
      r_acc    <= {{XLEN{1'b0}}, w_a_mag};
      r_b      <= w_b_mag;
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_neg_hi <= w_a_neg;
    end else if (r_active) begin
      r_acc <= w_step;
      if (done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/stage_ex_muldiv.sv
// Execute stage: base ALU / branch path with single-cycle latency plus an
// iterative mul/div path, all results registered behind a valid/ready pair.
module stage_ex_muldiv import exec_pkg::*; #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic            clk,
  input logic            rst,
  stage_ex_muldiv_if.slave bus
);
  ex_state_t       r_state, w_state_next;
  logic            r_out_valid, w_out_valid_next;
  logic [XLEN-1:0] r_alu_output, w_alu_next;
  logic [XLEN-1:0] r_branch_output, w_br_next;
  logic [1:0]      r_pcsrc, w_pcsrc_next;
  logic            r_illegal, w_illegal_next;
  logic            r_in_ready, r_busy;

  logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_y, w_branch_target;
  alu_ctrl_t       w_alu_ctrl;
  logic [1:0]      w_pcsrc;
  logic            w_is_mop, w_md_start, w_md_special, w_md_done;
  logic [XLEN-1:0] w_md_special_result, w_md_result;

  Mux_2to1 #(.W(XLEN)) u_mux_a (.sel(bus.a_sel), .d0(bus.rdata1), .d1(bus.pc),  .y(w_alu_a));
  Mux_2to1 #(.W(XLEN)) u_mux_b (.sel(bus.b_sel), .d0(bus.rdata2), .d1(bus.imm), .y(w_alu_b));
  ALU_Control u_alu_ctrl (.alu_op(bus.alu_op), .funct3(bus.funct3), .funct7_b5(bus.funct7[5]),
                          .alu_ctrl(w_alu_ctrl));
  ALU #(.XLEN(XLEN)) u_alu (.alu_ctrl(w_alu_ctrl), .a(w_alu_a), .b(w_alu_b), .y(w_alu_y));
  Branch_Unit #(.XLEN(XLEN)) u_branch (.pc_op(bus.pc_op), .funct3(bus.funct3),
                                       .rdata1(bus.rdata1), .rdata2(bus.rdata2), .pcsrc(w_pcsrc));
  Adder #(.W(XLEN)) u_br_add (.a(bus.pc), .b(bus.imm), .y(w_branch_target));

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk(clk), .rst(rst), .start(w_md_start), .op(bus.funct3),
    .a(bus.rdata1), .b(bus.rdata2),
    .special(w_md_special), .special_result(w_md_special_result),
    .done(w_md_done), .result(w_md_result)
  );

  assign w_is_mop = (bus.alu_op == ALUOP_RTYPE) && (bus.funct7 == FUNCT7_MULDIV);

  // Next state and next result registers; in_ready is only high in IDLE
  always_comb begin
    w_state_next     = r_state;
    w_out_valid_next = r_out_valid;
    w_alu_next       = r_alu_output;
    w_br_next        = r_branch_output;
    w_pcsrc_next     = r_pcsrc;
    w_illegal_next   = r_illegal;
    w_md_start       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_br_next      = w_branch_target;
          w_pcsrc_next   = w_pcsrc;
          w_illegal_next = 1'b0;
          if (w_is_mop && !ENABLE_M) begin
            w_alu_next       = '0;
            w_illegal_next   = 1'b1;
            w_state_next     = DONE;
            w_out_valid_next = 1'b1;
          end else if (w_is_mop && w_md_special) begin
            w_alu_next       = w_md_special_result;
            w_state_next     = DONE;
            w_out_valid_next = 1'b1;
          end else if (w_is_mop) begin
            w_md_start   = 1'b1;
            w_state_next = bus.funct3[2] ? DIV : MUL;
          end else begin
            w_alu_next       = w_alu_y;
            w_state_next     = DONE;
            w_out_valid_next = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (w_md_done) begin
          w_alu_next       = w_md_result;
          w_state_next     = DONE;
          w_out_valid_next = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next     = IDLE;
          w_out_valid_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_out_valid     <= 1'b0;
      r_alu_output    <= '0;
      r_branch_output <= '0;
      r_pcsrc         <= '0;
      r_illegal       <= 1'b0;
      r_in_ready      <= 1'b1;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_out_valid     <= w_out_valid_next;
      r_alu_output    <= w_alu_next;
      r_branch_output <= w_br_next;
      r_pcsrc         <= w_pcsrc_next;
      r_illegal       <= w_illegal_next;
      r_in_ready      <= (w_state_next == IDLE);
      r_busy          <= (w_state_next == MUL) || (w_state_next == DIV);
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.alu_output    = r_alu_output;
  assign bus.branch_output = r_branch_output;
  assign bus.pcsrc         = r_pcsrc;
  assign bus.illegal       = r_illegal;
  assign bus.busy          = r_busy;
endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Directed bench for stage_ex_muldiv: one full-M build and one ENABLE_M=0
// build share the stimulus; expected results go through a scoreboard queue.
module tb_stage_ex_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        t_in_valid, t_out_ready, t_a_sel, t_b_sel, use_nm;
  logic [1:0]  t_alu_op, t_pc_op;
  logic [2:0]  t_funct3;
  logic [6:0]  t_funct7;
  logic [31:0] t_pc, t_rdata1, t_rdata2, t_imm;

  stage_ex_muldiv_if #(.XLEN(XLEN)) bus ();
  stage_ex_muldiv_if #(.XLEN(XLEN)) bus_nm ();

  assign bus.in_valid     = t_in_valid & ~use_nm;
  assign bus.out_ready    = t_out_ready & ~use_nm;
  assign bus.a_sel        = t_a_sel;     assign bus_nm.a_sel  = t_a_sel;
  assign bus.b_sel        = t_b_sel;     assign bus_nm.b_sel  = t_b_sel;
  assign bus.alu_op       = t_alu_op;    assign bus_nm.alu_op = t_alu_op;
  assign bus.pc_op        = t_pc_op;     assign bus_nm.pc_op  = t_pc_op;
  assign bus.funct3       = t_funct3;    assign bus_nm.funct3 = t_funct3;
  assign bus.funct7       = t_funct7;    assign bus_nm.funct7 = t_funct7;
  assign bus.pc           = t_pc;        assign bus_nm.pc     = t_pc;
  assign bus.rdata1       = t_rdata1;    assign bus_nm.rdata1 = t_rdata1;
  assign bus.rdata2       = t_rdata2;    assign bus_nm.rdata2 = t_rdata2;
  assign bus.imm          = t_imm;       assign bus_nm.imm    = t_imm;
  assign bus_nm.in_valid  = t_in_valid & use_nm;
  assign bus_nm.out_ready = t_out_ready & use_nm;

  wire        obs_valid = use_nm ? bus_nm.out_valid     : bus.out_valid;
  wire        obs_ready = use_nm ? bus_nm.in_ready      : bus.in_ready;
  wire        obs_busy  = use_nm ? bus_nm.busy          : bus.busy;
  wire        obs_ill   = use_nm ? bus_nm.illegal       : bus.illegal;
  wire [1:0]  obs_pcsrc = use_nm ? bus_nm.pcsrc         : bus.pcsrc;
  wire [31:0] obs_alu   = use_nm ? bus_nm.alu_output    : bus.alu_output;
  wire [31:0] obs_br    = use_nm ? bus_nm.branch_output : bus.branch_output;

  stage_ex_muldiv #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut    (.clk(clk), .rst(rst), .bus(bus));
  stage_ex_muldiv #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (.clk(clk), .rst(rst), .bus(bus_nm));

  typedef struct {
    string       tag;
    logic [31:0] alu;
    int          lat;
    logic [31:0] br;
    logic [1:0]  pcsrc;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] F7M = 7'h01;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input string tag, input logic nm, input logic as, input logic bs,
                        input logic [1:0] aop, input logic [1:0] pop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic [31:0] e_alu,
                        input int e_lat, input logic [1:0] e_pcsrc, input logic e_ill,
                        input int hold);
    exp_t e, got;
    int   lat;
    @(negedge clk);
    use_nm = nm; t_a_sel = as; t_b_sel = bs; t_alu_op = aop; t_pc_op = pop;
    t_funct3 = f3; t_funct7 = f7; t_pc = p; t_rdata1 = r1; t_rdata2 = r2; t_imm = im;
    t_in_valid = 1'b1;
    #1;
    chk({tag, " in_ready_idle"}, 32'(obs_ready), 32'd1);
    e.tag = tag; e.alu = e_alu; e.lat = e_lat; e.br = p + im; e.pcsrc = e_pcsrc; e.ill = e_ill;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    t_in_valid = 1'b0;
    lat = 1;
    while (!obs_valid && lat < 200) begin
      if (lat == 1) begin
        chk({tag, " busy_iter"}, 32'(obs_busy), 32'd1);
        chk({tag, " in_ready_iter"}, 32'(obs_ready), 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, " out_valid_seen"}, 32'(obs_valid), 32'd1);
    got = sb.pop_front();
    chk({got.tag, " alu_output"}, obs_alu, got.alu);
    chk({got.tag, " latency"}, 32'(lat), 32'(got.lat));
    chk({got.tag, " branch_output"}, obs_br, got.br);
    chk({got.tag, " pcsrc"}, 32'(obs_pcsrc), 32'(got.pcsrc));
    chk({got.tag, " illegal"}, 32'(obs_ill), 32'(got.ill));
    chk({got.tag, " busy_done"}, 32'(obs_busy), 32'd0);
    chk({got.tag, " in_ready_done"}, 32'(obs_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({got.tag, " hold_valid"}, 32'(obs_valid), 32'd1);
      chk({got.tag, " hold_alu"}, obs_alu, got.alu);
      chk({got.tag, " hold_branch"}, obs_br, got.br);
      chk({got.tag, " hold_pcsrc"}, 32'(obs_pcsrc), 32'(got.pcsrc));
      chk({got.tag, " hold_in_ready"}, 32'(obs_ready), 32'd0);
    end
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
    chk({got.tag, " valid_drop"}, 32'(obs_valid), 32'd0);
    chk({got.tag, " in_ready_back"}, 32'(obs_ready), 32'd1);
    $display("txn %-14s alu=0x%08h br=0x%08h pcsrc=%0d ill=%0d lat=%0d",
             got.tag, obs_alu, obs_br, obs_pcsrc, obs_ill, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; use_nm = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b0;
    t_a_sel = 1'b0; t_b_sel = 1'b0; t_alu_op = 2'b00; t_pc_op = 2'b00;
    t_funct3 = 3'd0; t_funct7 = 7'd0; t_pc = '0; t_rdata1 = '0; t_rdata2 = '0; t_imm = '0;
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset alu_output", bus.alu_output, 32'd0);
    chk("reset branch_output", bus.branch_output, 32'd0);
    chk("reset pcsrc", 32'(bus.pcsrc), 32'd0);
    chk("reset illegal", 32'(bus.illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    //     tag           nm  as bs aop    pop    f3    f7     pc           r1           r2           imm          exp          lat pcs   ill hold
    run_op("ADD",        0, 0, 0, 2'b10, 2'b00, 3'd0, 7'h00, 32'h1000,    32'd5,       32'd7,       32'h4,       32'd12,       1, 2'd0, 0, 0);
    run_op("MUL_16x16",  0, 0, 0, 2'b10, 2'b00, 3'd0, F7M,   32'h1004,    32'h00010000,32'h00010000,32'h8,       32'h00000000,33, 2'd0, 0, 0);
    run_op("MULHU_16x16",0, 0, 0, 2'b10, 2'b00, 3'd3, F7M,   32'h1008,    32'h00010000,32'h00010000,32'h8,       32'h00000001,33, 2'd0, 0, 0);
    run_op("MULH_m3x5",  0, 0, 0, 2'b10, 2'b00, 3'd1, F7M,   32'h100C,    32'hFFFFFFFD,32'd5,       32'h8,       32'hFFFFFFFF,33, 2'd0, 0, 0);
    run_op("MUL_m3x5",   0, 1, 1, 2'b10, 2'b00, 3'd0, F7M,   32'h1010,    32'hFFFFFFFD,32'd5,       32'h55,      32'hFFFFFFF1,33, 2'd0, 0, 0);
    run_op("MULHSU_min2",0, 0, 0, 2'b10, 2'b00, 3'd2, F7M,   32'h1014,    32'h80000000,32'd2,       32'h8,       32'hFFFFFFFF,33, 2'd0, 0, 0);
    run_op("MULHU_ones", 0, 0, 0, 2'b10, 2'b00, 3'd3, F7M,   32'h1018,    32'hFFFFFFFF,32'hFFFFFFFF,32'h8,       32'hFFFFFFFE,33, 2'd0, 0, 0);
    run_op("DIV_m7_2",   0, 0, 0, 2'b10, 2'b00, 3'd4, F7M,   32'h101C,    32'hFFFFFFF9,32'd2,       32'h8,       32'hFFFFFFFD,33, 2'd0, 0, 0);
    run_op("REM_m7_2",   0, 0, 0, 2'b10, 2'b00, 3'd6, F7M,   32'h1020,    32'hFFFFFFF9,32'd2,       32'h8,       32'hFFFFFFFF,33, 2'd0, 0, 0);
    run_op("DIV_7_m2",   0, 0, 0, 2'b10, 2'b00, 3'd4, F7M,   32'h1024,    32'd7,       32'hFFFFFFFE,32'h8,       32'hFFFFFFFD,33, 2'd0, 0, 0);
    run_op("REM_7_m2",   0, 0, 0, 2'b10, 2'b00, 3'd6, F7M,   32'h1028,    32'd7,       32'hFFFFFFFE,32'h8,       32'h00000001,33, 2'd0, 0, 0);
    run_op("DIVU_100_7", 0, 0, 0, 2'b10, 2'b00, 3'd5, F7M,   32'h102C,    32'd100,     32'd7,       32'h8,       32'd14,      33, 2'd0, 0, 0);
    run_op("REMU_100_7", 0, 0, 0, 2'b10, 2'b00, 3'd7, F7M,   32'h1030,    32'd100,     32'd7,       32'h8,       32'd2,       33, 2'd0, 0, 0);
    run_op("DIVU_7_0",   0, 0, 0, 2'b10, 2'b00, 3'd5, F7M,   32'h1034,    32'd7,       32'd0,       32'h8,       32'hFFFFFFFF, 1, 2'd0, 0, 0);
    run_op("REMU_7_0",   0, 0, 0, 2'b10, 2'b00, 3'd7, F7M,   32'h1038,    32'd7,       32'd0,       32'h8,       32'd7,        1, 2'd0, 0, 0);
    run_op("REM_ovf",    0, 0, 0, 2'b10, 2'b00, 3'd6, F7M,   32'h103C,    32'h80000000,32'hFFFFFFFF,32'h8,       32'h00000000, 1, 2'd0, 0, 0);
    run_op("DIV_ovf",    0, 0, 0, 2'b10, 2'b00, 3'd4, F7M,   32'h1040,    32'h80000000,32'hFFFFFFFF,32'h8,       32'h80000000, 1, 2'd0, 0, 0);
    run_op("DIVU_min_m1",0, 0, 0, 2'b10, 2'b00, 3'd5, F7M,   32'h1044,    32'h80000000,32'hFFFFFFFF,32'h8,       32'h00000000,33, 2'd0, 0, 0);
    run_op("BEQ_taken",  0, 0, 0, 2'b01, 2'b01, 3'd0, 7'h00, 32'h100,     32'd9,       32'd9,       32'h20,      32'h00000000, 1, 2'd1, 0, 3);
    run_op("BNE_not",    0, 0, 0, 2'b01, 2'b01, 3'd1, 7'h00, 32'h104,     32'd9,       32'd9,       32'h40,      32'h00000000, 1, 2'd0, 0, 0);
    run_op("SRA",        0, 0, 0, 2'b10, 2'b00, 3'd5, 7'h20, 32'h108,     32'h80000000,32'd4,       32'h0,       32'hF8000000, 1, 2'd0, 0, 0);
    run_op("ADDI",       0, 0, 1, 2'b11, 2'b00, 3'd0, 7'h20, 32'h10C,     32'h10,      32'h99,      32'h5,       32'h15,       1, 2'd0, 0, 0);
    run_op("AUIPC",      0, 1, 1, 2'b00, 2'b00, 3'd0, 7'h00, 32'h200,     32'h77,      32'h66,      32'h1000,    32'h1200,     1, 2'd0, 0, 0);
    run_op("BLT_taken",  0, 0, 0, 2'b01, 2'b01, 3'd4, 7'h00, 32'h300,     32'hFFFFFFFF,32'd1,       32'h10,      32'hFFFFFFFE, 1, 2'd1, 0, 0);

    // Reset in the middle of a divide: the op is abandoned and nothing is produced
    begin
      exp_t e;
      @(negedge clk);
      use_nm = 1'b0; t_a_sel = 1'b0; t_b_sel = 1'b0; t_alu_op = 2'b10; t_pc_op = 2'b00;
      t_funct3 = 3'd4; t_funct7 = F7M; t_pc = 32'h40; t_rdata1 = 32'hFFFFFFF9; t_rdata2 = 32'd2;
      t_imm = 32'h8; t_in_valid = 1'b1;
      e.tag = "DIV_reset"; e.alu = 32'hFFFFFFFD; e.lat = 33; e.br = 32'h48; e.pcsrc = 2'd0; e.ill = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      t_in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("DIV_reset busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("DIV_reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("DIV_reset busy", 32'(bus.busy), 32'd0);
      chk("DIV_reset alu_output", bus.alu_output, 32'd0);
      chk("DIV_reset branch_output", bus.branch_output, 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("DIV_reset in_ready_after", 32'(bus.in_ready), 32'd1);
      $display("txn %-14s reset at iteration 10, op abandoned", "DIV_reset");
    end

    run_op("ADD_post_rst",0, 0, 0, 2'b10, 2'b00, 3'd0, 7'h00, 32'h500,    32'd5,       32'd7,       32'h4,       32'd12,       1, 2'd0, 0, 0);
    run_op("NM_MUL",     1, 0, 0, 2'b10, 2'b00, 3'd0, F7M,   32'h600,     32'hFFFFFFFD,32'd5,       32'h4,       32'h00000000, 1, 2'd0, 1, 0);
    run_op("NM_DIV",     1, 0, 0, 2'b10, 2'b00, 3'd4, F7M,   32'h604,     32'd7,       32'd0,       32'h4,       32'h00000000, 1, 2'd0, 1, 0);
    run_op("NM_ADD",     1, 0, 0, 2'b10, 2'b00, 3'd0, 7'h00, 32'h608,     32'd5,       32'd7,       32'h4,       32'd12,       1, 2'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_ex_muldiv.md
Name: stage_ex_muldiv

Overview:
Parametrised execute stage for the multicycle core. It keeps the existing base ALU, branch-compare and branch-target path, and adds iterative RV32M multiply/divide. A valid/ready handshake is used on both sides so the controller FSM can wait on variable latency. The stage sits between the ID/register-read step and the MEM/WB steps, and all of its outputs are registered.

Parameters:
XLEN, 32, datapath width for operands, results and pc.
ENABLE_M, 1, when 1 the M-extension ops execute; when 0 they are flagged illegal.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation presented on the inputs
in_ready  out  1  stage can accept an operation
a_sel  in  1  ALU A mux select: 0=rdata1, 1=pc
b_sel  in  1  ALU B mux select: 0=rdata2, 1=imm
alu_op  in  2  team ALU-op encoding; 2'b10 = R-type
pc_op  in  2  branch/jump class for the Branch_Unit
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
pc  in  XLEN  instruction pc
rdata1  in  XLEN  rs1 data
rdata2  in  XLEN  rs2 data
imm  in  XLEN  immediate
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer accepts the result
alu_output  out  XLEN  ALU or mul/div result
branch_output  out  XLEN  pc + imm
pcsrc  out  2  next-pc select
illegal  out  1  M-op issued while ENABLE_M=0
busy  out  1  high in MUL or DIV state

Behaviour:
- Reset (async, any state): state=IDLE; out_valid, alu_output, branch_output, pcsrc, illegal and busy all 0; iteration counter 0. A reset mid-operation abandons the op and produces no output.
- States: IDLE, MUL, DIV, DONE. in_ready=1 only in IDLE.
- Accept: a transfer occurs when in_valid && in_ready. At that point the stage latches the operands, funct3, branch_output=pc+imm and pcsrc from the Branch_Unit (compare on rdata1/rdata2).
- M-op decode: alu_op==2'b10 && funct7==7'b0000001.
  - funct3 0-3 are MUL/MULH/MULHSU/MULHU.
  - funct3 4-7 are DIV/DIVU/REM/REMU.
  - mul/div always use rdata1/rdata2, ignoring a_sel/b_sel.
- Base op, or M-op with ENABLE_M=0: IDLE -> DONE. out_valid rises on the cycle after accept (latency 1). If ENABLE_M=0 and the op is an M-op: alu_output=0 and illegal=1.
- Division special cases take the 1-cycle path to DONE:
  - divisor==0: quotient = all-ones, remainder = dividend.
  - signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend, remainder = 0.
- MUL: radix-2 shift-add on operand magnitudes with a 2*XLEN product register, XLEN iterations.
  - Signedness: MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU and MUL unsigned (MUL takes the low word).
  - The product is negated on the final iteration when the sign of the result is negative.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV: restoring division on magnitudes, XLEN iterations.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Iterative latency: accept at cycle 0, iterations on cycles 1..XLEN, out_valid at cycle XLEN+1. busy=1 throughout MUL/DIV.
- DONE: out_valid=1 and all outputs are held stable until out_ready. On out_valid && out_ready, DONE -> IDLE and out_valid=0 the next cycle. No new accept happens in that same cycle.
- in_valid in any non-IDLE state is ignored; the upstream holds its inputs.
- Iteration counter width is $clog2(XLEN+1). It wraps to 0 on exit and never free-runs.

Decomposition:
- Package exec_pkg holds:
  - ALUOP_RTYPE=2'b10
  - FUNCT7_MULDIV=7'b0000001
  - the funct3 codes for MUL..REMU
  - the state enum IDLE/MUL/DIV/DONE
- One sub-module, muldiv_iter (parameter XLEN), contains the shift registers, counter, sign fix-up and special-case detect. It exposes start / op / done.
- The base path instantiates the existing Mux_2to1, ALU_Control, ALU, Branch_Unit and Adder unchanged.

Test Plan:
- ADD with rdata1=5, rdata2=7, alu_op=2'b10, funct7=0 -> out_valid one cycle after accept, alu_output=12.
- MUL 0x00010000*0x00010000 -> 0x00000000 at cycle 33. MULHU on the same operands -> 0x00000001. MULH -3*5 -> 0xFFFFFFFF. MUL -3*5 -> 0xFFFFFFF1.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF with latency 1. REM 0x80000000/-1 -> 0 with latency 1.
- BEQ with rdata1=rdata2=9, pc=0x100, imm=0x20 -> branch_output=0x120 and taken pcsrc. Hold out_ready low for 3 cycles -> outputs stable, in_ready=0 throughout.
- Assert rst at cycle 10 of a DIV -> out_valid, busy, alu_output = 0 immediately; in_ready=1 after rst falls; the next ADD completes normally.
- ENABLE_M=0 build, MUL issued -> illegal=1, alu_output=0, latency 1.
